// File: rtl/dispense_timer.sv
// Interval dispense timer: counts a locked two-digit BCD setting down once per prescaler tick,
// then runs the feeder motor for a fixed time, pulses done and repeats while the setting stays locked.
module dispense_timer #(
  parameter int TICK_DIV        = 50000000,
  parameter int DISPENSE_CYCLES = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [3:0] unitsR,
  input  logic [3:0] decadesR,
  output logic       motor_on,
  output logic       done,
  output logic       busy,
  output logic       cfg_err,
  output logic [3:0] cnt_units,
  output logic [3:0] cnt_decades
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int DW = (DISPENSE_CYCLES > 1) ? $clog2(DISPENSE_CYCLES) : 1;
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DISP_LAST = DW'(DISPENSE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, COUNT, DISPENSE} state_t;

  state_t        state_reg;
  logic [PW-1:0] prescaler_reg;
  logic [DW-1:0] dcnt_reg;
  logic          setting_ok;
  logic          tick;
  logic          last_tick;
  logic          disp_end;

  assign setting_ok = (unitsR <= 4'd9) && (decadesR <= 4'd9) &&
                      !((unitsR == 4'd0) && (decadesR == 4'd0));
  assign tick       = (prescaler_reg == TICK_LAST);
  assign last_tick  = (cnt_decades == 4'd0) && (cnt_units == 4'd1);
  assign disp_end   = (dcnt_reg == DISP_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      prescaler_reg <= '0;
      dcnt_reg      <= '0;
      motor_on      <= 1'b0;
      done          <= 1'b0;
      busy          <= 1'b0;
      cfg_err       <= 1'b0;
      cnt_units     <= 4'd0;
      cnt_decades   <= 4'd0;
    end else begin
      cfg_err <= enable & ~setting_ok;
      done    <= 1'b0;
      case (state_reg)
        IDLE: begin
          motor_on      <= 1'b0;
          prescaler_reg <= '0;
          if (enable && setting_ok) begin
            cnt_units   <= unitsR;
            cnt_decades <= decadesR;
            busy        <= 1'b1;
            state_reg   <= COUNT;
          end else begin
            cnt_units   <= 4'd0;
            cnt_decades <= 4'd0;
            busy        <= 1'b0;
          end
        end

        COUNT: begin
          // Losing the lock wins over a tick landing on the same edge.
          if (!enable) begin
            state_reg     <= IDLE;
            busy          <= 1'b0;
            prescaler_reg <= '0;
            cnt_units     <= 4'd0;
            cnt_decades   <= 4'd0;
          end else if (tick) begin
            prescaler_reg <= '0;
            if (cnt_units != 4'd0) begin
              cnt_units <= cnt_units - 4'd1;
            end else if (cnt_decades != 4'd0) begin
              cnt_units   <= 4'd9;
              cnt_decades <= cnt_decades - 4'd1;
            end
            if (last_tick) begin
              motor_on  <= 1'b1;
              dcnt_reg  <= '0;
              state_reg <= DISPENSE;
            end
          end else begin
            prescaler_reg <= prescaler_reg + 1'b1;
          end
        end

        DISPENSE: begin
          if (disp_end) begin
            motor_on <= 1'b0;
            done     <= 1'b1;
            // The end-of-dispense edge doubles as the next load edge.
            if (enable && setting_ok) begin
              cnt_units     <= unitsR;
              cnt_decades   <= decadesR;
              prescaler_reg <= '0;
              state_reg     <= COUNT;
            end else begin
              busy      <= 1'b0;
              state_reg <= IDLE;
            end
          end else begin
            dcnt_reg <= dcnt_reg + 1'b1;
          end
        end

        default: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
          motor_on  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dispense_timer.sv
// Bench for dispense_timer: a time-based model (remaining = N - elapsed/TICK_DIV) checked every
// negedge, plus hand-computed checks at the key edges of each directed scenario.
`timescale 1ns/1ps
module tb_dispense_timer;
  localparam int TD = 4;
  localparam int DC = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enable = 1'b0;
  logic [3:0] unitsR = 4'd0;
  logic [3:0] decadesR = 4'd0;
  logic       motor_on, done, busy, cfg_err;
  logic [3:0] cnt_units, cnt_decades;

  int n_vec = 0;
  int n_fail = 0;

  dispense_timer #(.TICK_DIV(TD), .DISPENSE_CYCLES(DC)) dut (
    .clk(clk), .rst(rst), .enable(enable), .unitsR(unitsR), .decadesR(decadesR),
    .motor_on(motor_on), .done(done), .busy(busy), .cfg_err(cfg_err),
    .cnt_units(cnt_units), .cnt_decades(cnt_decades)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  function automatic bit valid_setting(input logic [3:0] d, input logic [3:0] u);
    return (d <= 9) && (u <= 9) && (d * 10 + u != 0);
  endfunction

  // Model: 0 = idle, 1 = counting, 2 = dispensing; time measured in edges since reset.
  int m_mode, m_n, m_load, m_ds, cyc;
  bit e_done, e_cfg;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode = 0; m_n = 0; m_load = 0; m_ds = 0; cyc = 0;
      e_done = 0; e_cfg = 0;
    end else begin
      cyc++;
      e_done = 0;
      e_cfg  = enable && !valid_setting(decadesR, unitsR);
      case (m_mode)
        0: if (enable && valid_setting(decadesR, unitsR)) begin
             m_n = decadesR * 10 + unitsR; m_load = cyc; m_mode = 1;
           end
        1: if (!enable) m_mode = 0;
           else if (cyc - m_load == m_n * TD) begin m_mode = 2; m_ds = cyc; end
        default: if (cyc - m_ds == DC) begin
             e_done = 1;
             if (enable && valid_setting(decadesR, unitsR)) begin
               m_n = decadesR * 10 + unitsR; m_load = cyc; m_mode = 1;
             end else m_mode = 0;
           end
      endcase
    end
  end

  always @(negedge clk) begin
    int rem;
    rem = (m_mode == 1) ? m_n - (cyc - m_load) / TD : 0;
    check("motor_on", {7'd0, motor_on}, {7'd0, m_mode == 2});
    check("done",     {7'd0, done},     {7'd0, e_done});
    check("busy",     {7'd0, busy},     {7'd0, m_mode != 0});
    check("cfg_err",  {7'd0, cfg_err},  {7'd0, e_cfg});
    check("cnt",      {cnt_decades, cnt_units}, {4'(rem / 10), 4'(rem % 10)});
  end

  task automatic adv(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #2 rst = 1'b1;
    #1;
    check("rst_async_motor", {7'd0, motor_on}, 8'd0);
    check("rst_async_cnt", {cnt_decades, cnt_units}, 8'h00);
    check("rst_async_busy", {7'd0, busy}, 8'd0);
    #14 rst = 1'b0;
    adv(3);
    check("idle_cnt", {cnt_decades, cnt_units}, 8'h00);
    check("idle_busy", {7'd0, busy}, 8'd0);

    // Basic 03 cycle with reload
    decadesR = 4'd0; unitsR = 4'd3; enable = 1'b1;
    adv(1);  check("basic_L", {cnt_decades, cnt_units}, 8'h03);
    adv(4);  check("basic_L4", {cnt_decades, cnt_units}, 8'h02);
    adv(4);  check("basic_L8", {cnt_decades, cnt_units}, 8'h01);
    adv(4);  check("basic_L12_motor", {7'd0, motor_on}, 8'd1);
             check("basic_L12_cnt", {cnt_decades, cnt_units}, 8'h00);
    adv(3);  check("basic_L15_done", {7'd0, done}, 8'd1);
             check("basic_L15_motor", {7'd0, motor_on}, 8'd0);
             check("basic_L15_reload", {cnt_decades, cnt_units}, 8'h03);
    adv(1);  check("basic_L16_done", {7'd0, done}, 8'd0);
    adv(10); check("basic_L26_motor", {7'd0, motor_on}, 8'd0);
    adv(1);  check("basic_L27_motor", {7'd0, motor_on}, 8'd1);
    enable = 1'b0;
    adv(2);  check("disp_hold_motor", {7'd0, motor_on}, 8'd1);
    adv(1);  check("disp_end_done", {7'd0, done}, 8'd1);
             check("disp_end_busy", {7'd0, busy}, 8'd0);

    // Borrow from 10
    decadesR = 4'd1; unitsR = 4'd0; enable = 1'b1;
    adv(1);  check("borrow_L", {cnt_decades, cnt_units}, 8'h10);
    adv(4);  check("borrow_L4", {cnt_decades, cnt_units}, 8'h09);
    adv(35); check("borrow_L39_motor", {7'd0, motor_on}, 8'd0);
    adv(1);  check("borrow_L40_motor", {7'd0, motor_on}, 8'd1);
    enable = 1'b0;
    adv(3);  check("borrow_idle", {7'd0, busy}, 8'd0);

    // Abort from 05
    decadesR = 4'd0; unitsR = 4'd5; enable = 1'b1;
    adv(1);
    adv(8);  check("abort_L8", {cnt_decades, cnt_units}, 8'h03);
    enable = 1'b0;
    adv(1);  check("abort_busy", {7'd0, busy}, 8'd0);
             check("abort_cnt", {cnt_decades, cnt_units}, 8'h00);
    adv(25); check("abort_motor", {7'd0, motor_on}, 8'd0);

    // Invalid settings, then corrected
    decadesR = 4'd0; unitsR = 4'hA; enable = 1'b1;
    adv(1);  check("inv_A_cfg", {7'd0, cfg_err}, 8'd1);
             check("inv_A_busy", {7'd0, busy}, 8'd0);
    unitsR = 4'd0;
    adv(1);  check("inv_00_cfg", {7'd0, cfg_err}, 8'd1);
             check("inv_00_busy", {7'd0, busy}, 8'd0);
    unitsR = 4'd2;
    adv(1);  check("fix_cfg", {7'd0, cfg_err}, 8'd0);
             check("fix_cnt", {cnt_decades, cnt_units}, 8'h02);
    adv(8);  check("fix_L8_motor", {7'd0, motor_on}, 8'd1);

    // Reset during dispense
    adv(1);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_motor", {7'd0, motor_on}, 8'd0);
    check("rst_mid_busy", {7'd0, busy}, 8'd0);
    unitsR = 4'd1;
    #3 rst = 1'b0;
    adv(1);  check("rst_L", {cnt_decades, cnt_units}, 8'h01);
    adv(3);  check("rst_L3_motor", {7'd0, motor_on}, 8'd0);
    adv(1);  check("rst_L4_motor", {7'd0, motor_on}, 8'd1);
    enable = 1'b0;
    adv(4);  check("final_idle", {7'd0, busy}, 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule

// File: doc/dispense_timer.md
Name: dispense_timer

Overview:
- Consumer of the two-digit BCD setting produced by the keypad/memory block, which drives enable, unitsR and decadesR.
- While the setting is locked (enable=1), loads the BCD interval and counts it down one unit per prescaler tick.
- At zero, drives the feeder motor for a fixed number of cycles, pulses done, then reloads the interval and repeats.
- Exposes the live remaining count in BCD for the display path.

Parameters:
- TICK_DIV, 50000000, clk cycles per countdown unit (1 s at 50 MHz); minimum 2.
- DISPENSE_CYCLES, 25000000, cycles motor_on is held high per dispense; minimum 1.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous active-high reset.
- enable  input  1  setting locked/valid from memory block; level, synchronous to clk.
- unitsR  input  4  BCD units of the interval.
- decadesR  input  4  BCD decades of the interval.
- motor_on  output  1  feeder motor drive, registered.
- done  output  1  one-cycle pulse at end of each dispense.
- busy  output  1  high in COUNT or DISPENSE.
- cfg_err  output  1  registered; high while enable=1 and the setting is invalid.
- cnt_units  output  4  remaining-time units, BCD.
- cnt_decades  output  4  remaining-time decades, BCD.

Behaviour:
- Reset (async, immediate, no clock needed):
  - state=IDLE; prescaler=0.
  - All outputs 0: motor_on, done, busy, cfg_err, cnt_units, cnt_decades.
- Valid setting: both digits ≤ 9 and not 00.
- cfg_err is registered each edge as enable AND NOT valid, in every state.
- States: IDLE, COUNT, DISPENSE (registered FSM, all outputs registered).
- IDLE:
  - Counts held at 00; motor_on=0.
  - On an edge with enable=1 and a valid setting (the load edge, L): cnt <= {decadesR, unitsR}, prescaler <= 0, state <= COUNT, busy <= 1.
  - Otherwise remain in IDLE.
- COUNT:
  - prescaler increments every cycle.
  - On the edge where prescaler==TICK_DIV-1 (a tick): prescaler <= 0 and cnt decrements in BCD.
  - BCD decrement: if units≠0, units-1; else units <= 9 and decades-1.
  - Ticks land at edges L+k*TICK_DIV, k=1,2,...
  - On the tick that takes cnt from 01 to 00, the same edge sets motor_on <= 1 and state <= DISPENSE.
  - For a setting of N, motor_on rises at edge L+N*TICK_DIV.
  - enable=0 on any edge in COUNT aborts: state <= IDLE, cnt <= 00, busy <= 0, prescaler <= 0, no dispense. Abort takes priority over a coincident tick.
  - Digit inputs are ignored after the load edge; changes take effect only at load or reload.
- DISPENSE:
  - motor_on stays high for exactly DISPENSE_CYCLES cycles and is never cut short by enable.
  - Final edge, D = entry + DISPENSE_CYCLES: motor_on <= 0 and done <= 1 for one cycle.
  - At D, if enable=1 and the setting is valid: reload cnt from inputs, prescaler <= 0, state <= COUNT. D acts as the new load edge L.
  - At D otherwise: state <= IDLE, busy <= 0, cnt stays 00.
- done is 0 in all other cycles.
- busy equals (state != IDLE) as registered.
- Maximum setting 99 counts 99 ticks with no wrap. Counters never underflow below 00.

Test Plan (TICK_DIV=4, DISPENSE_CYCLES=3):
- Reset: assert rst mid-sim with no clock edge -> all outputs 0 immediately; after release with enable=0, stay IDLE, cnt=00.
- Basic cycle: decadesR=0, unitsR=3, enable=1, load edge L ->
  - cnt=03, 02, 01, 00 at L+4, L+8, L+12.
  - motor_on=1 from L+12 through L+15; done=1 one cycle at L+15.
  - Reload to 03 at L+15; next motor_on at L+27.
- Borrow: load 10 -> after L+4 cnt_decades=0, cnt_units=9; motor_on rises at L+40.
- Abort: load 05, drop enable at L+9 -> next edge state IDLE, cnt=00, busy=0, motor_on never asserts.
- Invalid settings:
  - unitsR=4'hA with enable=1 -> cfg_err=1, busy stays 0.
  - 00 with enable=1 -> cfg_err=1, no load.
  - Correcting the setting to 02 -> cfg_err=0 next edge and load.
- Reset mid-dispense: assert rst while motor_on=1 -> motor_on=0 asynchronously, state IDLE; after release with enable=1, setting 01 -> motor_on at L+4.
